// File: rtl/mc_switch_alloc_if.sv
// Handshake bundle for mc_switch_alloc: per-input head flits with destination masks, registered
// output flits with downstream full flags, and the optional statistics counters.
interface mc_switch_alloc_if #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned DATASIZE  = 30,
  parameter int unsigned CNT_W     = 32
);
  logic [NUM_PORTS*DATASIZE-1:0]  in_data;
  logic [NUM_PORTS-1:0]           in_valid;
  logic [NUM_PORTS*NUM_PORTS-1:0] in_dest;
  logic [NUM_PORTS-1:0]           in_ready;
  logic [NUM_PORTS*DATASIZE-1:0]  out_data;
  logic [NUM_PORTS-1:0]           out_valid;
  logic [NUM_PORTS-1:0]           out_full_in;
  logic [CNT_W-1:0]               flit_cnt;
  logic [CNT_W-1:0]               drop_cnt;

  modport master (
    output in_data, in_valid, in_dest, out_full_in,
    input  in_ready, out_data, out_valid, flit_cnt, drop_cnt
  );

  modport slave (
    input  in_data, in_valid, in_dest, out_full_in,
    output in_ready, out_data, out_valid, flit_cnt, drop_cnt
  );
endinterface

// File: rtl/mc_switch_alloc.sv
// Multicast-aware round-robin switch allocator and registered crossbar.
// Define MCSA_STATS_EN to build the saturating flit/drop statistics counters.
module mc_switch_alloc #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned DATASIZE  = 30,
  parameter int unsigned CNT_W     = 32
) (
  input logic               clk,
  input logic               rst_n,
  mc_switch_alloc_if.slave  bus
);
  localparam int unsigned   PtrW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PtrW:0] NumP    = (PtrW+1)'(NUM_PORTS);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_PORTS - 1);

  logic [NUM_PORTS-1:0]                active_q, active_d;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] pending_q, pending_d, req, rem, gnt_to;
  logic [NUM_PORTS-1:0][PtrW-1:0]      ptr_q, ptr_d, win;
  logic [NUM_PORTS-1:0]                out_gnt;
  logic [NUM_PORTS-1:0][DATASIZE-1:0]  in_flit, out_data_q, out_data_d;
  logic [NUM_PORTS-1:0]                out_valid_q, out_valid_d;

  // Effective request: the residual of a partly delivered multicast, else the fresh mask.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_flit[i] = bus.in_data[i*DATASIZE +: DATASIZE];
      if (!bus.in_valid[i])  req[i] = '0;
      else if (active_q[i])  req[i] = pending_q[i];
      else                   req[i] = bus.in_dest[i*NUM_PORTS +: NUM_PORTS];
    end
  end

  always_comb begin
    logic [PtrW:0]   sum;
    logic [PtrW-1:0] sel;
    sum     = '0;
    sel     = '0;
    out_gnt = '0;
    win     = '0;
    gnt_to  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        sum = {1'b0, ptr_q[o]} + (PtrW+1)'(k);
        if (sum >= NumP) sum = sum - NumP;
        sel = sum[PtrW-1:0];
        if (!out_gnt[o] && !bus.out_full_in[o] && req[sel][o]) begin
          out_gnt[o]     = 1'b1;
          win[o]         = sel;
          gnt_to[sel][o] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      rem[i]          = req[i] & ~gnt_to[i];
      // rst_n is active-high: no pops while reset is asserted.
      bus.in_ready[i] = !rst_n && bus.in_valid[i] && (rem[i] == '0);
      active_d[i]     = bus.in_valid[i] && (rem[i] != '0);
      pending_d[i]    = active_d[i] ? rem[i] : '0;
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_valid_d[o] = out_gnt[o];
      out_data_d[o]  = out_gnt[o] ? in_flit[win[o]] : out_data_q[o];
      if (!out_gnt[o])              ptr_d[o] = ptr_q[o];
      else if (win[o] == LastIdx)   ptr_d[o] = '0;
      else                          ptr_d[o] = win[o] + 1'b1;
      bus.out_data[o*DATASIZE +: DATASIZE] = out_data_q[o];
    end
    bus.out_valid = out_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      active_q    <= '0;
      pending_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      active_q    <= active_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef MCSA_STATS_EN
  logic [CNT_W-1:0] flit_cnt_q, drop_cnt_q;
  logic [PtrW:0]    flit_add, drop_add;
  logic [CNT_W:0]   flit_sum, drop_sum;

  always_comb begin
    flit_add = '0;
    drop_add = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      flit_add = flit_add + (PtrW+1)'(out_valid_d[i]);
      drop_add = drop_add + (PtrW+1)'(bus.in_valid[i] && !active_q[i] &&
                                      (bus.in_dest[i*NUM_PORTS +: NUM_PORTS] == '0));
    end
    flit_sum = {1'b0, flit_cnt_q} + (CNT_W+1)'(flit_add);
    drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_add);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      flit_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      flit_cnt_q <= flit_sum[CNT_W] ? '1 : flit_sum[CNT_W-1:0];
      drop_cnt_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

  assign bus.flit_cnt = flit_cnt_q;
  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.flit_cnt = '0;
  assign bus.drop_cnt = '0;
`endif
endmodule
